// File: rtl/power_sequencer.sv
// rtl/power_sequencer.sv - staged enable sequencer: ordered bring-up, reverse-order teardown
// Optional macro SEQ_STAGE_ACK_EN: teardown waits for each stage's stage_ack to drop (with timeout).
module power_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int CNT_WIDTH   = 32,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run,
   input  logic [CNT_WIDTH-1:0]  stage_delay,
`ifdef SEQ_STAGE_ACK_EN
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic                  timeout_err,
`endif
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  all_up,
   output logic                  all_down
);

   localparam int IDX_W = $clog2(NUM_STAGES + 1);
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_STAGES);

   typedef enum logic [2:0] {
      ST_DOWN,
      ST_RAMP_UP,
      ST_UP,
      ST_RAMP_DOWN,
      ST_WAIT_ACK
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] counter;
   logic [IDX_W-1:0]     idx;
   logic                 step_due;
   logic [IDX_W-1:0]     idx_inc;
   logic [IDX_W-1:0]     idx_dec;

   // Live compare, so lowering stage_delay mid-step shortens the current wait.
   assign step_due = (counter >= stage_delay);
   assign idx_inc  = idx + 1'b1;
   assign idx_dec  = idx - 1'b1;

   // Enables are always the contiguous low block of idx stages.
   function automatic logic [NUM_STAGES-1:0] low_mask(input logic [IDX_W-1:0] n);
      logic [NUM_STAGES-1:0] m;
      for (int i = 0; i < NUM_STAGES; i++) begin
         m[i] = (i < int'(n));
      end
      return m;
   endfunction

`ifdef SEQ_STAGE_ACK_EN
   localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   logic [ACK_W-1:0] ack_cnt;
   logic             ack_active;

   // idx already points at the stage just cleared.
   assign ack_active = |(stage_ack & (NUM_STAGES'(1) << idx));
`else
   if (ACK_TIMEOUT < 1) begin : g_ack_timeout_unused
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_DOWN;
         counter  <= '0;
         idx      <= '0;
         stage_en <= '0;
         all_up   <= 1'b0;
         all_down <= 1'b1;
`ifdef SEQ_STAGE_ACK_EN
         ack_cnt     <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         case (state)
            ST_DOWN: begin
               if (run) begin
                  state    <= ST_RAMP_UP;
                  counter  <= '0;
                  all_down <= 1'b0;
               end
            end

            ST_RAMP_UP: begin
               if (!run) begin
                  counter <= '0;
                  if (idx == '0) begin
                     state    <= ST_DOWN;
                     all_down <= 1'b1;
                  end else begin
                     state <= ST_RAMP_DOWN;
                  end
               end else if (step_due) begin
                  idx      <= idx_inc;
                  stage_en <= low_mask(idx_inc);
                  counter  <= '0;
                  if (idx_inc == IDX_FULL) begin
                     state  <= ST_UP;
                     all_up <= 1'b1;
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end

            ST_UP: begin
               if (!run) begin
                  state   <= ST_RAMP_DOWN;
                  counter <= '0;
                  all_up  <= 1'b0;
               end
            end

            ST_RAMP_DOWN: begin
               if (run) begin
                  counter <= '0;
                  if (idx == IDX_FULL) begin
                     state  <= ST_UP;
                     all_up <= 1'b1;
                  end else begin
                     state <= ST_RAMP_UP;
                  end
               end else if (step_due) begin
                  idx      <= idx_dec;
                  stage_en <= low_mask(idx_dec);
                  counter  <= '0;
`ifdef SEQ_STAGE_ACK_EN
                  state   <= ST_WAIT_ACK;
                  ack_cnt <= '0;
`else
                  if (idx_dec == '0) begin
                     state    <= ST_DOWN;
                     all_down <= 1'b1;
                  end
`endif
               end else begin
                  counter <= counter + 1'b1;
               end
            end

`ifdef SEQ_STAGE_ACK_EN
            ST_WAIT_ACK: begin
               if (run) begin
                  state   <= ST_RAMP_UP;
                  counter <= '0;
               end else if (!ack_active || ack_cnt == ACK_LAST) begin
                  if (ack_active) begin
                     timeout_err <= 1'b1;
                  end
                  counter <= '0;
                  if (idx == '0) begin
                     state    <= ST_DOWN;
                     all_down <= 1'b1;
                  end else begin
                     state <= ST_RAMP_DOWN;
                  end
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
`endif

            default: begin
               state    <= ST_DOWN;
               counter  <= '0;
               idx      <= '0;
               stage_en <= '0;
               all_up   <= 1'b0;
               all_down <= 1'b1;
            end
         endcase
      end
   end

endmodule
